airlock_sequencer: RTL

//  Central FSM for the airlock: sequences outer/inner port control, fill-and-pressurize and evacuate.

---
 rtl/airlock_pkg.sv | 25 ++
 rtl/airlock_sequencer_if.sv | 17 +
 rtl/airlock_sequencer_sec_countdown.sv | 23 ++
 rtl/airlock_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock sequencer: state encoding, count width, durations.
package airlock_pkg;
  localparam int COUNT_W = 4;

  localparam logic [2:0] S_EVAC_IDLE  = 3'd0;
  localparam logic [2:0] S_OUTER_OPEN = 3'd1;
  localparam logic [2:0] S_FILLING    = 3'd2;
  localparam logic [2:0] S_PRESS_IDLE = 3'd3;
  localparam logic [2:0] S_INNER_OPEN = 3'd4;
  localparam logic [2:0] S_EVACUATING = 3'd5;

  typedef enum logic [2:0] {
    EVAC_IDLE  = S_EVAC_IDLE,
    OUTER_OPEN = S_OUTER_OPEN,
    FILLING    = S_FILLING,
    PRESS_IDLE = S_PRESS_IDLE,
    INNER_OPEN = S_INNER_OPEN,
    EVACUATING = S_EVACUATING
  } al_state_e;

  localparam int TICKS_PER_SEC_DEF = 95;
  localparam int FP_SECS_DEF       = 7;
  localparam int EV_SECS_DEF       = 8;
  localparam int DOCK_SECS_DEF     = 5;
endpackage

// File: rtl/airlock_sequencer_if.sv
// Request pulses into, and status out of, the airlock sequencer.
interface airlock_sequencer_if;
  import airlock_pkg::*;
  logic               arrive_req, depart_req, outer_tog, inner_tog, fp_req, ev_req;
  logic               outer_open, inner_open, pressurized, evacuated, busy;
  logic [1:0]         dock_led;
  logic [COUNT_W-1:0] op_count, dock_count;

  modport master (
    output arrive_req, depart_req, outer_tog, inner_tog, fp_req, ev_req,
    input  outer_open, inner_open, pressurized, evacuated, busy, dock_led, op_count, dock_count
  );
  modport slave (
    input  arrive_req, depart_req, outer_tog, inner_tog, fp_req, ev_req,
    output outer_open, inner_open, pressurized, evacuated, busy, dock_led, op_count, dock_count
  );
endinterface

// File: rtl/airlock_sequencer_sec_countdown.sv
// Seconds countdown: load wins, then clear, else step down on tick; saturates at 0.
module sec_countdown
  import airlock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic               tick,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic               done
);
  // done flags the edge on which count goes 1->0, so callers can act on that same edge
  assign done = tick && !load && !clear && (count == COUNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (load)                    count <= load_val;
    else if (clear)                   count <= '0;
    else if (tick && count != '0)     count <= count - COUNT_W'(1);
  end
endmodule

// File: rtl/airlock_sequencer.sv
// Airlock FSM with port interlocks, shared second tick, op and dock countdowns.
// Optional AIRLOCK_ABORT_EN: a port toggle during FILLING/EVACUATING aborts the op.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int FP_SECS       = FP_SECS_DEF,
  parameter int EV_SECS       = EV_SECS_DEF,
  parameter int DOCK_SECS     = DOCK_SECS_DEF
)(
  input  logic                clk,
  input  logic                rst_n,
  airlock_sequencer_if.slave  bus
);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  al_state_e                   state, nxt;
  logic [TW-1:0]               tick_cnt;
  logic                        tick, restart;
  logic                        op_load, op_clear, dock_acc;
  logic [COUNT_W-1:0]          op_val;
  logic [1:0]                  cd_load, cd_clear, cd_done;
  logic [1:0][COUNT_W-1:0]     cd_val, cd_count;
  logic                        outer_q, inner_q, press_q, evac_q, busy_q;
  logic [1:0]                  led_q;

  assign tick = (tick_cnt == TW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (restart || tick)  tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + TW'(1);
  end

  // index 0: FP/EV operation, index 1: docking
  assign cd_load  = {dock_acc, op_load};
  assign cd_clear = {1'b0, op_clear};
  assign cd_val   = {COUNT_W'(DOCK_SECS), op_val};

  for (genvar g = 0; g < 2; g++) begin : g_cd
    sec_countdown u_cd (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cd_load[g]),
      .clear    (cd_clear[g]),
      .tick     (tick),
      .load_val (cd_val[g]),
      .count    (cd_count[g]),
      .done     (cd_done[g])
    );
  end

  assign dock_acc = (bus.arrive_req || bus.depart_req) && (cd_count[1] == '0) &&
                    (state == EVAC_IDLE || state == OUTER_OPEN);
  assign restart  = op_load || dock_acc;

`ifdef AIRLOCK_ABORT_EN
  logic tgl;
  assign tgl = bus.outer_tog || bus.inner_tog;
`endif

  // a legal port toggle outranks an fp/ev request; illegal pulses simply fall through
  always_comb begin
    nxt      = state;
    op_load  = 1'b0;
    op_clear = 1'b0;
    op_val   = COUNT_W'(FP_SECS);
    case (state)
      EVAC_IDLE: begin
        if (bus.outer_tog) nxt = OUTER_OPEN;
        else if (bus.fp_req) begin
          nxt = FILLING; op_load = 1'b1; op_val = COUNT_W'(FP_SECS);
        end
      end
      OUTER_OPEN: if (bus.outer_tog) nxt = EVAC_IDLE;
      FILLING: begin
`ifdef AIRLOCK_ABORT_EN
        if (tgl) begin nxt = EVAC_IDLE; op_clear = 1'b1; end
        else
`endif
        if (cd_done[0]) nxt = PRESS_IDLE;
      end
      PRESS_IDLE: begin
        if (bus.inner_tog) nxt = INNER_OPEN;
        else if (bus.ev_req) begin
          nxt = EVACUATING; op_load = 1'b1; op_val = COUNT_W'(EV_SECS);
        end
      end
      INNER_OPEN: if (bus.inner_tog) nxt = PRESS_IDLE;
      EVACUATING: begin
`ifdef AIRLOCK_ABORT_EN
        if (tgl) begin nxt = PRESS_IDLE; op_clear = 1'b1; end
        else
`endif
        if (cd_done[0]) nxt = EVAC_IDLE;
      end
      default: nxt = EVAC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EVAC_IDLE;
      outer_q <= 1'b0;
      inner_q <= 1'b0;
      press_q <= 1'b0;
      evac_q  <= 1'b1;
      busy_q  <= 1'b0;
      led_q   <= 2'b00;
    end else begin
      state   <= nxt;
      outer_q <= (nxt == OUTER_OPEN);
      inner_q <= (nxt == INNER_OPEN);
      press_q <= (nxt == PRESS_IDLE) || (nxt == INNER_OPEN);
      evac_q  <= (nxt == EVAC_IDLE)  || (nxt == OUTER_OPEN);
      busy_q  <= (nxt == FILLING)    || (nxt == EVACUATING);
      if (dock_acc)        led_q <= bus.arrive_req ? 2'b01 : 2'b10;
      else if (cd_done[1]) led_q <= 2'b00;
    end
  end

  assign bus.outer_open  = outer_q;
  assign bus.inner_open  = inner_q;
  assign bus.pressurized = press_q;
  assign bus.evacuated   = evac_q;
  assign bus.busy        = busy_q;
  assign bus.dock_led    = led_q;
  assign bus.op_count    = cd_count[0];
  assign bus.dock_count  = cd_count[1];
endmodule
